pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter TRAP_PC, default 32'h0000_0100, PC loaded on misaligned target.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_valid  input  1  instruction memory returns imem_rdata this cycle.
REQ-006 imem_rdata  input  32  fetched instruction word.
REQ-007 exec_done  input  1  datapath finished current instruction.
REQ-008 is_branch, is_jal, is_jalr  input  1 each  decoded control-transfer class.
REQ-009 branch_taken  input  1  condition result from branch decode ROM.
REQ-010 imm  input  32  sign-extended immediate.
REQ-011 rs1_val  input  32  rs1 register value.
REQ-012 pc  output  32  current PC, registered.
REQ-013 pc_plus4  output  32  pc+4, combinational, for link write.
REQ-014 imem_req, imem_addr  output  1, 32  fetch request and address (imem_addr = pc).
REQ-015 instr, instr_valid  output  32, 1  latched instruction and its valid flag, registered.
REQ-016 trap  output  1  one-cycle pulse on misaligned control transfer.

Function
REQ-017 FSM states IDLE, FETCH, EXEC, TRAP; IDLE -> FETCH unconditionally next cycle.
REQ-018 FETCH: imem_req=1; on imem_valid=1, instr<=imem_rdata, instr_valid<=1, next state EXEC; otherwise hold.
REQ-019 imem_valid in any state other than FETCH SHALL be ignored.
REQ-020 EXEC: imem_req=0, instr and instr_valid held until exec_done=1.
REQ-021 On exec_done in EXEC, next PC priority: is_jalr -> (rs1_val+imm) with bit0 cleared; else is_jal -> pc+imm; else is_branch & branch_taken -> pc+imm; else pc+4.
REQ-022 branch_taken SHALL be ignored when is_branch=0.
REQ-023 All PC arithmetic modulo 2^32; pc=32'hFFFF_FFFC sequential next is 32'h0000_0000.
REQ-024 Next PC with bits[1:0]!=0: pc<=TRAP_PC, trap=1 for exactly one cycle, state TRAP, then FETCH.
REQ-025 Aligned next PC: pc<=next, state FETCH; instr_valid<=0 on the same edge.
REQ-026 Latency: imem_valid to instr_valid one edge; exec_done to imem_req for new pc one edge.
REQ-027 exec_done outside EXEC SHALL be ignored.

Reset
REQ-028 On rst: state IDLE, pc=RESET_PC, imem_req=0, instr=32'h0000_0013, instr_valid=0, trap=0, immediately and independent of clk.
REQ-029 Reset during FETCH or EXEC SHALL abandon the transaction; pending imem_valid after deassertion discarded until FETCH.

Structure
REQ-030 Shared package holds state enum, XLEN=32, NOP constant 32'h0000_0013.
REQ-031 One sub-module natural: pc_next_calc (combinational next-PC and misalignment check).

Verification
REQ-032 Reset, then imem_valid with 32'h0000_0013 after 2 wait cycles -> imem_addr 0, instr_valid after 1 edge; exec_done -> pc=4.
REQ-033 pc=0x40, is_branch=1, branch_taken=1, imm=-8 -> pc=0x38; branch_taken=0 -> pc=0x44.
REQ-034 is_jalr, rs1_val=0x1001, imm=0 -> pc=0x1000, no trap; is_jal with imm=0x6 -> trap pulse, pc=0x100.
REQ-035 pc=0xFFFF_FFFC sequential -> pc=0x0000_0000.
REQ-036 rst asserted mid-EXEC -> outputs at reset values same cycle; is_jal+is_jalr both high -> jalr target chosen.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: datapath width, the NOP encoding
// used as the reset value of the instruction latch, and FSM state encodings.
package pc_sequencer_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StFetch = 2'd1;
  localparam state_t StExec  = 2'd2;
  localparam state_t StTrap  = 2'd3;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection and alignment check.
// Ports:
//   pc, imm, rs1_val            operands for target arithmetic
//   is_branch, is_jal, is_jalr  decoded control-transfer class
//   branch_taken                condition result, only meaningful with is_branch
//   next_pc                     selected target (modulo 2^XLEN)
//   misaligned                  target is not 4-byte aligned
module pc_next_calc
  import pc_sequencer_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            branch_taken,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  always_comb begin
    next_pc = pc + 32'd4;
    if (is_jalr) begin
      next_pc    = rs1_val + imm;
      next_pc[0] = 1'b0;
    end else if (is_jal || (is_branch && branch_taken)) begin
      next_pc = pc + imm;
    end
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction, holds it while the
// datapath executes, then advances the PC (sequential, branch, jal, jalr) or
// redirects to TRAP_PC on a misaligned target.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_valid, imem_rdata   instruction memory response
//   exec_done                datapath finished the current instruction
//   is_branch/jal/jalr       decoded control-transfer class
//   branch_taken, imm, rs1_val  next-PC operands
//   pc, pc_plus4             current PC and link value
//   imem_req, imem_addr      fetch request
//   instr, instr_valid       latched instruction
//   trap                     one-cycle misaligned-target pulse
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            exec_done,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic            trap
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  pc_next_calc u_pc_next_calc (
    .pc           (pc_q),
    .imm          (imm),
    .rs1_val      (rs1_val),
    .is_branch    (is_branch),
    .is_jal       (is_jal),
    .is_jalr      (is_jalr),
    .branch_taken (branch_taken),
    .next_pc      (next_pc),
    .misaligned   (misaligned)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_valid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = StExec;
        end
      end
      StExec: begin
        if (exec_done) begin
          // The held instruction is retired whichever way the PC goes.
          instr_valid_d = 1'b0;
          if (misaligned) begin
            pc_d    = TRAP_PC;
            state_d = StTrap;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
        end
      end
      StTrap:  state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == StFetch);
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  // TRAP lasts exactly one cycle, so decoding the state yields the pulse.
  assign trap        = (state_q == StTrap);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        exec_done;
  logic        is_branch, is_jal, is_jalr, branch_taken;
  logic [31:0] imm, rs1_val;
  logic [31:0] pc, pc_plus4, imem_addr, instr;
  logic        imem_req, instr_valid, trap;

  int n_vec = 0;
  int n_err = 0;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .exec_done    (exec_done),
    .is_branch    (is_branch),
    .is_jal       (is_jal),
    .is_jalr      (is_jalr),
    .branch_taken (branch_taken),
    .imm          (imm),
    .rs1_val      (rs1_val),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .trap         (trap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction word in FETCH; afterwards the DUT is in EXEC.
  task automatic fetch(input logic [31:0] word);
    imem_valid = 1'b1;
    imem_rdata = word;
    step();
    imem_valid = 1'b0;
  endtask

  task automatic exec(input logic jalr, input logic jal, input logic br, input logic tk,
                      input logic [31:0] im, input logic [31:0] rs1);
    is_jalr = jalr; is_jal = jal; is_branch = br; branch_taken = tk;
    imm = im; rs1_val = rs1; exec_done = 1'b1;
    step();
    exec_done = 1'b0; is_jalr = 1'b0; is_jal = 1'b0; is_branch = 1'b0; branch_taken = 1'b0;
    imm = '0; rs1_val = '0;
  endtask

  initial begin
    rst = 1'b1; imem_valid = 1'b0; imem_rdata = '0; exec_done = 1'b0;
    is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; branch_taken = 1'b0;
    imm = '0; rs1_val = '0;
    #2;
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_req", {31'b0, imem_req}, 32'h0);
    check_eq("rst_instr", instr, 32'h0000_0013);
    check_eq("rst_ivalid", {31'b0, instr_valid}, 32'h0);
    check_eq("rst_trap", {31'b0, trap}, 32'h0);
    step();
    rst = 1'b0;
    step();  // IDLE -> FETCH
    check_eq("fetch_req", {31'b0, imem_req}, 32'h1);
    check_eq("fetch_addr", imem_addr, 32'h0);
    check_eq("pc_plus4", pc_plus4, 32'h4);
    // exec_done outside EXEC is ignored
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    step();
    check_eq("wait_pc", pc, 32'h0);
    check_eq("wait_req", {31'b0, imem_req}, 32'h1);
    fetch(32'h0000_0013);
    check_eq("first_ivalid", {31'b0, instr_valid}, 32'h1);
    check_eq("first_instr", instr, 32'h0000_0013);
    check_eq("exec_req", {31'b0, imem_req}, 32'h0);
    // imem_valid during EXEC must not disturb the latched word
    imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_valid = 1'b0;
    check_eq("exec_ignore_imem", instr, 32'h0000_0013);
    exec(0, 0, 0, 0, 32'h0, 32'h0);
    check_eq("seq_pc", pc, 32'h4);
    check_eq("seq_req", {31'b0, imem_req}, 32'h1);
    check_eq("seq_ivalid", {31'b0, instr_valid}, 32'h0);

    // Reach pc=0x40 via jal
    fetch(32'h0000_006F); exec(0, 1, 0, 0, 32'h3C, 32'h0);
    check_eq("jal_pc", pc, 32'h40);
    fetch(32'h0000_0063); exec(0, 0, 1, 1, 32'hFFFF_FFF8, 32'h0);
    check_eq("br_taken_pc", pc, 32'h38);
    fetch(32'h0000_006F); exec(0, 0, 0, 0, 32'h0, 32'h0);
    fetch(32'h0000_006F); exec(0, 1, 0, 0, 32'h4, 32'h0);
    check_eq("back_to_40", pc, 32'h40);
    fetch(32'h0000_0063); exec(0, 0, 1, 0, 32'hFFFF_FFF8, 32'h0);
    check_eq("br_not_taken_pc", pc, 32'h44);
    // branch_taken without is_branch is sequential
    fetch(32'h0000_0013); exec(0, 0, 0, 1, 32'h100, 32'h0);
    check_eq("taken_no_branch", pc, 32'h48);

    fetch(32'h0000_0067); exec(1, 0, 0, 0, 32'h0, 32'h1001);
    check_eq("jalr_pc", pc, 32'h1000);
    check_eq("jalr_no_trap", {31'b0, trap}, 32'h0);
    fetch(32'h0000_006F); exec(0, 1, 0, 0, 32'h6, 32'h0);
    check_eq("mis_trap", {31'b0, trap}, 32'h1);
    check_eq("mis_pc", pc, 32'h100);
    check_eq("mis_req", {31'b0, imem_req}, 32'h0);
    step();
    check_eq("trap_pulse_end", {31'b0, trap}, 32'h0);
    check_eq("trap_to_fetch", {31'b0, imem_req}, 32'h1);

    fetch(32'h0000_0067); exec(1, 0, 0, 0, 32'h0, 32'hFFFF_FFFC);
    check_eq("near_top_pc", pc, 32'hFFFF_FFFC);
    fetch(32'h0000_0013); exec(0, 0, 0, 0, 32'h0, 32'h0);
    check_eq("wrap_pc", pc, 32'h0);

    fetch(32'h0000_0067); exec(1, 1, 0, 0, 32'h4, 32'h300);
    check_eq("jalr_over_jal", pc, 32'h304);

    // Reset in the middle of EXEC
    fetch(32'h00A0_0093);
    check_eq("pre_rst_instr", instr, 32'h00A0_0093);
    #3;
    rst = 1'b1;
    imem_valid = 1'b1; imem_rdata = 32'h1234_5678;
    #1;
    check_eq("mid_rst_pc", pc, 32'h0);
    check_eq("mid_rst_instr", instr, 32'h0000_0013);
    check_eq("mid_rst_ivalid", {31'b0, instr_valid}, 32'h0);
    check_eq("mid_rst_req", {31'b0, imem_req}, 32'h0);
    step();
    rst = 1'b0;
    step();  // IDLE: pending imem_valid must be discarded
    check_eq("post_rst_ivalid", {31'b0, instr_valid}, 32'h0);
    check_eq("post_rst_instr", instr, 32'h0000_0013);
    check_eq("post_rst_req", {31'b0, imem_req}, 32'h1);
    step();
    imem_valid = 1'b0;
    check_eq("post_rst_fetch", instr, 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
